clk_div_prog: RTL and testbench

Runtime-programmable integer clock divider. Generates a 50%-duty divided clock for both odd and even divisors from one source clock. Divisor changes are glitch-free: a new value is taken only at a period boundary, so no runt pulses reach downstream clocked logic. Sits at the clock-generation level and feeds slow peripheral domains and enable strobes.

---
 rtl/clk_div_prog.sv | 96 +++++++++
 tb/tb_clk_div_prog.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable 50%-duty clock divider, odd and even N,
// glitch-free divisor update at period boundaries.
// Ports: clk, rst_n (async low), en, load, div_val -> div_out, cur_div,
// upd (apply pulse), err (sticky illegal load). Optional CLK_DIV_PULSE_EN
// adds div_pulse, a one-cycle same-domain strobe per output period.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_val,
  output logic             div_out,
  output logic [WIDTH-1:0] cur_div,
  output logic             upd,
  output logic             err
`ifdef CLK_DIV_PULSE_EN
  ,
  output logic             div_pulse
`endif
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] last;
  logic             pos_q;
  logic             neg_q;
  logic             pending;
  logic             run;
  logic             bnd;
  logic             low;

  assign half = cur_div >> 1;
  assign last = cur_div - ONE;
  // A started period always completes, even after en drops.
  assign run  = en | (cnt != '0);
  assign bnd  = (cnt == last);
  assign low  = (div_val < MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pos_q   <= 1'b0;
      cur_div <= DEF;
      shadow  <= '0;
      pending <= 1'b0;
      upd     <= 1'b0;
      err     <= 1'b0;
    end else begin
      upd <= bnd & pending;
      if (bnd) begin
        cnt   <= '0;
        pos_q <= 1'b0;
        if (pending)
          cur_div <= shadow;
      end else if (run) begin
        cnt   <= cnt + ONE;
        pos_q <= (cnt < half);
      end else begin
        cnt   <= '0;
        pos_q <= 1'b0;
      end
      // A load on the boundary cycle re-arms pending after the apply.
      if (load) begin
        shadow  <= low ? MIN : div_val;
        pending <= 1'b1;
      end else if (bnd) begin
        pending <= 1'b0;
      end
      err <= err | (load & low);
    end
  end

  // Half-cycle extension only for odd N; masking here keeps div_out
  // a single OR of two flops.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)
      neg_q <= 1'b0;
    else
      neg_q <= pos_q & cur_div[0];
  end

  assign div_out = pos_q | neg_q;

`ifdef CLK_DIV_PULSE_EN
  assign div_pulse = rst_n & en & (cnt == '0);
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed and random checks of clk_div_prog against
// a period/half-cycle reference model.
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [7:0] div_val = '0;
  logic       div_out;
  logic [7:0] cur_div;
  logic       upd;
  logic       err;
`ifdef CLK_DIV_PULSE_EN
  logic       div_pulse;
`endif

  int checks = 0;
  int errors = 0;

  // model: mk = edge index inside current period (-1 idle),
  // pn = divisor of current period, mn = divisor in force
  int mk;
  int pn;
  int mn;
  int msh;
  bit mpend;
  bit merr;
  bit mupd;

  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .load(load),
    .div_val(div_val),
    .div_out(div_out),
    .cur_div(cur_div),
    .upd(upd),
    .err(err)
`ifdef CLK_DIV_PULSE_EN
    ,
    .div_pulse(div_pulse)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mk = -1; pn = 5; mn = 5; msh = 0;
    mpend = 0; merr = 0; mupd = 0;
  endtask

  task automatic step(input bit e, input bit l, input int v);
    int  nk;
    bit  bnd;
    en = e; load = l; div_val = 8'(v);
    @(posedge clk);
    if (mk < 0 || mk == pn - 1)
      nk = e ? 0 : -1;
    else
      nk = mk + 1;
    if (nk == 0 && (mk < 0 || mk == pn - 1))
      pn = mn;
    bnd = (nk >= 0) && (nk == pn - 1);
    mupd = bnd && mpend;
    if (bnd && mpend)
      mn = msh;
    if (l) begin
      msh = (v < 2) ? 2 : v;
      mpend = 1;
    end else if (bnd) begin
      mpend = 0;
    end
    if (l && v < 2)
      merr = 1;
    mk = nk;
    #1;
    chk("div_out_pos", div_out, (mk >= 0) && (2 * mk < pn));
    chk("cur_div", cur_div, mn);
    chk("upd", upd, mupd);
    chk("err", err, merr);
`ifdef CLK_DIV_PULSE_EN
    chk("div_pulse", div_pulse, e && (mk < 0 || mk == pn - 1));
`endif
    @(negedge clk);
    #1;
    chk("div_out_neg", div_out, (mk >= 0) && (2 * mk + 1 < pn));
  endtask

  task automatic run_until(input int k, input int d);
    bit hit = 0;
    for (int i = 0; i < 60; i++) begin
      if (mk == k && mn == d) begin
        hit = 1;
        break;
      end
      step(1, 0, 0);
    end
    chk("wait_timeout", hit, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_div_out", div_out, 0);
    chk("rst_cur_div", cur_div, 5);
    chk("rst_upd", upd, 0);
    chk("rst_err", err, 0);
    load = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_hold", div_out, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    #12;
    chk("init_div_out", div_out, 0);
    chk("init_cur_div", cur_div, 5);
    chk("init_upd", upd, 0);
    chk("init_err", err, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // default divisor 5: 25 high / 25 low
    repeat (12) step(1, 0, 0);

    // load 6 during cnt==2
    run_until(1, 5);
    step(1, 1, 6);
    repeat (14) step(1, 0, 0);
    chk("dir_div6", cur_div, 6);

    // two loads inside one period: last wins
    run_until(0, 6);
    step(1, 1, 3);
    step(1, 1, 7);
    repeat (16) step(1, 0, 0);
    chk("dir_div7", cur_div, 7);

    // illegal load clamps to 2, err sticky
    step(1, 1, 1);
    repeat (20) step(1, 0, 0);
    chk("dir_div2", cur_div, 2);
    chk("dir_err", err, 1);

    // en drop at cnt==1 of N=4, then restart
    step(1, 1, 4);
    run_until(0, 4);
    repeat (8) step(0, 0, 0);
    repeat (10) step(1, 0, 0);

    // reset in the high phase of N=5
    step(1, 1, 5);
    run_until(0, 5);
    do_reset();
    repeat (12) step(1, 0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit e;
      bit l;
      int v;
      e = ($urandom % 12) != 0;
      l = ($urandom % 7) == 0;
      v = (($urandom % 10) == 0) ? int'($urandom % 2)
                                 : int'($urandom_range(2, 11));
      step(e, l, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
